credit_checker: RTL

//  Parametrised vending-machine credit unit: accumulates inserted coins, holds a per-item price table,

---
 rtl/credit_pkg.sv | 23 ++
 rtl/credit_price_table.sv | 34 +++
 rtl/credit_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: shared FSM state encoding and default money-quantity settings
// for the vending-machine credit unit.
package credit_pkg;

    // Default width of every money quantity, in cents.
    localparam int MONEY_W_DEF    = 13;
    // Default credit ceiling, only enforced when CREDIT_LIMIT_EN is defined.
    localparam int MAX_CREDIT_DEF = 5000;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CHECK  = ST_CHECK,
        VEND   = ST_VEND,
        CHANGE = ST_CHANGE
    } state_t;

endpackage

// File: rtl/credit_price_table.sv
// credit_price_table: per-item price registers with synchronous write and
// asynchronous read; every entry returns to DEFAULT_PRICE on reset.
module credit_price_table #(
    parameter int MONEY_W       = 13,
    parameter int N_ITEMS       = 4,
    parameter int ITEM_W        = 2,
    parameter int DEFAULT_PRICE = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [ITEM_W-1:0]  i_widx,
    input  logic [MONEY_W-1:0] i_wdata,
    input  logic [ITEM_W-1:0]  i_ridx,
    output logic [MONEY_W-1:0] o_rdata
);

    logic [MONEY_W-1:0] r_price [N_ITEMS];

    // Price storage: reset to the default price, written one entry at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                r_price[i] <= MONEY_W'(DEFAULT_PRICE);
            end
        end else if (i_we && (int'(i_widx) < N_ITEMS)) begin
            r_price[i_widx] <= i_wdata;
        end
    end

    // Indices beyond the table read as zero rather than an undefined entry.
    assign o_rdata = (int'(i_ridx) < N_ITEMS) ? r_price[i_ridx] : '0;

endmodule

// File: rtl/credit_checker.sv
// credit_checker: accumulates coins, checks credit against the selected
// item's price and issues vend and change/refund handshakes.
// Optional feature: define CREDIT_LIMIT_EN to reject any coin that would push
// credit above MAX_CREDIT; otherwise credit saturates at 2**MONEY_W-1.
module credit_checker
    import credit_pkg::*;
#(
    parameter int MONEY_W       = MONEY_W_DEF,
    parameter int N_ITEMS       = 4,
    parameter int ITEM_W        = 2,
    parameter int DEFAULT_PRICE = 100,
    parameter int MAX_CREDIT    = MAX_CREDIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    output logic               coin_reject,
    input  logic               price_we,
    input  logic [ITEM_W-1:0]  price_idx,
    input  logic [MONEY_W-1:0] price_wdata,
    input  logic [ITEM_W-1:0]  item_sel,
    input  logic               buy_req,
    input  logic               cancel,
    output logic [MONEY_W-1:0] credit,
    output logic               sufficient,
    output logic               vend_valid,
    output logic [ITEM_W-1:0]  vend_item,
    output logic               deny,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amt,
    input  logic               change_ack
);

    state_t             r_state, w_state_nxt;
    logic [MONEY_W-1:0] r_credit, w_credit_nxt;
    logic [MONEY_W-1:0] r_change_amt, w_change_amt_nxt;
    logic [MONEY_W-1:0] r_price_lat, w_price_lat_nxt;
    logic [ITEM_W-1:0]  r_item, w_item_nxt;
    logic [ITEM_W-1:0]  r_vend_item, w_vend_item_nxt;
    logic               r_coin_reject, w_coin_reject_nxt;
    logic               r_deny, w_deny_nxt;
    logic               r_sufficient;

    logic [MONEY_W-1:0] w_price_sel;
    logic [MONEY_W:0]   w_sum;
    logic [MONEY_W-1:0] w_coin_total;
    logic               w_coin_ok;

    credit_price_table #(
        .MONEY_W       (MONEY_W),
        .N_ITEMS       (N_ITEMS),
        .ITEM_W        (ITEM_W),
        .DEFAULT_PRICE (DEFAULT_PRICE)
    ) u_price_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (price_we),
        .i_widx  (price_idx),
        .i_wdata (price_wdata),
        .i_ridx  (item_sel),
        .o_rdata (w_price_sel)
    );

    // One extra bit so an overflowing coin is detected rather than wrapped.
    assign w_sum = {1'b0, r_credit} + {1'b0, coin_value};

`ifdef CREDIT_LIMIT_EN
    assign w_coin_ok    = (w_sum <= (MONEY_W+1)'(MAX_CREDIT));
    assign w_coin_total = w_sum[MONEY_W-1:0];
`else
    function automatic logic [MONEY_W-1:0] f_sat(input logic [MONEY_W:0] sum);
        return sum[MONEY_W] ? {MONEY_W{1'b1}} : sum[MONEY_W-1:0];
    endfunction

    // The ceiling is irrelevant without the limit; keep the parameter referenced.
    logic w_unused_max;
    assign w_unused_max = (MAX_CREDIT != 0);

    assign w_coin_ok    = 1'b1;
    assign w_coin_total = f_sat(w_sum);
`endif

    // Next-state and datapath updates for the credit FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_change_amt_nxt  = r_change_amt;
        w_price_lat_nxt   = r_price_lat;
        w_item_nxt        = r_item;
        w_vend_item_nxt   = r_vend_item;
        w_coin_reject_nxt = 1'b0;
        w_deny_nxt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (cancel) begin
                    // A refund drops any coin and purchase arriving with it.
                    w_coin_reject_nxt = coin_valid;
                    if (r_credit != '0) begin
                        w_change_amt_nxt = r_credit;
                        w_credit_nxt     = '0;
                        w_state_nxt      = CHANGE;
                    end
                end else begin
                    if (coin_valid) begin
                        if (w_coin_ok) begin
                            w_credit_nxt = w_coin_total;
                        end else begin
                            w_coin_reject_nxt = 1'b1;
                        end
                    end
                    if (buy_req) begin
                        w_item_nxt      = item_sel;
                        w_price_lat_nxt = w_price_sel;
                        w_state_nxt     = CHECK;
                    end
                end
            end
            CHECK: begin
                w_coin_reject_nxt = coin_valid;
                if (r_credit >= r_price_lat) begin
                    w_credit_nxt    = r_credit - r_price_lat;
                    w_vend_item_nxt = r_item;
                    w_state_nxt     = VEND;
                end else begin
                    w_deny_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            VEND: begin
                w_coin_reject_nxt = coin_valid;
                if (r_credit != '0) begin
                    w_change_amt_nxt = r_credit;
                    w_credit_nxt     = '0;
                    w_state_nxt      = CHANGE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CHANGE: begin
                w_coin_reject_nxt = coin_valid;
                if (change_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, credit datapath and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_change_amt  <= '0;
            r_price_lat   <= '0;
            r_item        <= '0;
            r_vend_item   <= '0;
            r_coin_reject <= 1'b0;
            r_deny        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_change_amt  <= w_change_amt_nxt;
            r_price_lat   <= w_price_lat_nxt;
            r_item        <= w_item_nxt;
            r_vend_item   <= w_vend_item_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_deny        <= w_deny_nxt;
        end
    end

    // Affordability of the currently selected item, one cycle behind credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sufficient <= 1'b0;
        end else begin
            r_sufficient <= (r_credit >= w_price_sel);
        end
    end

    assign credit       = r_credit;
    assign sufficient   = r_sufficient;
    assign coin_reject  = r_coin_reject;
    assign deny         = r_deny;
    assign vend_valid   = (r_state == VEND);
    assign vend_item    = r_vend_item;
    assign change_valid = (r_state == CHANGE);
    assign change_amt   = r_change_amt;

endmodule
